// File: rtl/tx_char_queue.sv
// Byte FIFO feeding a parallel-to-serial transmitter: pops one byte per frame,
// holds load/enable through the frame, retires on tx_done or timeout, then idles a gap.
module tx_char_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    output logic              tx_enable,
    input  logic              tx_done,
    output logic              busy,
    output logic              timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t              state_q, state_d;
    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_on_q, tx_on_d;
    logic                overflow_q, overflow_d;
    logic                timeout_err_q, timeout_err_d;
    logic                wr_acc, pop;

    assign full        = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign tx_data     = tx_data_q;
    assign tx_load     = tx_on_q;
    assign tx_enable   = tx_on_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        gap_d         = gap_q;
        tx_data_d     = tx_data_q;
        tx_on_d       = tx_on_q;
        timeout_err_d = timeout_err_q;
        pop           = 1'b0;
        // full comes from the registered count, so a same-cycle pop never frees a slot
        wr_acc        = wr_en && !full;
        overflow_d    = overflow_q | (wr_en & full);

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    tx_on_d   = 1'b1;
                    timer_d   = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                timer_d = timer_q + 1'b1;
                if (tx_done || timer_q == TW'(TIMEOUT - 1)) begin
                    tx_on_d = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                    if (!tx_done) timeout_err_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
            tx_data_q     <= '0;
            tx_on_q       <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            tx_data_q     <= tx_data_d;
            tx_on_q       <= tx_on_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end
endmodule
